// File: rtl/chain_traceback.sv
`default_nettype none
// ============================================================================
// Module   : chain_traceback
// Purpose  : Reads the optimal cost m[1][n] from the matrix-chain solution
//            matrix, then walks the stored split indices and streams the
//            optimal parenthesization as MAT/OPEN/CLOSE tokens (valid/ready).
// Revision : 1.0 - initial release
// ============================================================================
module chain_traceback #(
    parameter int MAX_N  = 16,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  n,
    output logic        sol_rd,
    output logic        sol_sel,
    output logic [7:0]  sol_i,
    output logic [7:0]  sol_j,
    input  logic [31:0] sol_data,
    output logic [31:0] total_cost,
    output logic        cost_valid,
    output logic        tok_valid,
    input  logic        tok_ready,
    output logic [1:0]  tok_type,
    output logic [7:0]  tok_idx,
    output logic        busy,
    output logic        done,
    output logic        error
);
    localparam int DEPTH = 2 * MAX_N;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SPW   = $clog2(DEPTH + 1);
    localparam int CW    = $clog2(RD_LAT) + 1;

    localparam logic [1:0] TOK_MAT   = 2'd0;
    localparam logic [1:0] TOK_OPEN  = 2'd1;
    localparam logic [1:0] TOK_CLOSE = 2'd2;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_COST   = 3'd1,
        WAIT_COST = 3'd2,
        POP       = 3'd3,
        RD_K      = 3'd4,
        WAIT_K    = 3'd5,
        EMIT      = 3'd6,
        ERR       = 3'd7
    } state_t;

    state_t         state, state_nx;
    logic [SPW-1:0] sp;
    logic           stk_close [DEPTH];
    logic [7:0]     stk_i     [DEPTH];
    logic [7:0]     stk_j     [DEPTH];
    logic [7:0]     n_reg, cur_i, cur_j, root_j, k;
    logic [CW-1:0]  cnt;
    logic           cnt_hit;
    logic [AW-1:0]  top_idx, p0, p1, p2;
    logic           top_close;
    logic [7:0]     top_i, top_j;
    logic           start_acc, ld_root, load_cost, pop_en, push_split, ld_tok;
    logic [1:0]     tok_type_nx;
    logic [7:0]     tok_idx_nx;

    assign k         = sol_data[7:0];
    assign cnt_hit   = (cnt == CW'(RD_LAT - 1));
    assign top_idx   = AW'(sp - SPW'(1));
    assign p0        = AW'(sp);
    assign p1        = AW'(sp + SPW'(1));
    assign p2        = AW'(sp + SPW'(2));
    assign top_close = stk_close[top_idx];
    assign top_i     = stk_i[top_idx];
    assign top_j     = stk_j[top_idx];
    // n==1 pushes its leaf in the same cycle start is taken, before n_reg loads
    assign root_j    = start_acc ? n : n_reg;

    assign busy      = (state != IDLE) && (state != ERR);
    assign error     = (state == ERR);
    assign tok_valid = (state == EMIT);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state, read strobes and datapath control
    always_comb begin
        state_nx    = state;
        sol_rd      = 1'b0;
        sol_sel     = 1'b0;
        sol_i       = 8'd0;
        sol_j       = 8'd0;
        done        = 1'b0;
        start_acc   = 1'b0;
        ld_root     = 1'b0;
        load_cost   = 1'b0;
        pop_en      = 1'b0;
        push_split  = 1'b0;
        ld_tok      = 1'b0;
        tok_type_nx = TOK_MAT;
        tok_idx_nx  = 8'd0;
        unique case (state)
            IDLE, ERR: begin
                if (start) begin
                    start_acc = 1'b1;
                    if (n == 8'd0 || int'(n) > MAX_N) begin
                        state_nx = ERR;
                    end else if (n == 8'd1) begin
                        ld_root  = 1'b1;
                        state_nx = POP;
                    end else begin
                        state_nx = RD_COST;
                    end
                end
            end
            RD_COST: begin
                sol_rd   = 1'b1;
                sol_i    = 8'd1;
                sol_j    = n_reg;
                state_nx = WAIT_COST;
            end
            WAIT_COST: begin
                if (cnt_hit) begin
                    load_cost = 1'b1;
                    ld_root   = 1'b1;
                    state_nx  = POP;
                end
            end
            POP: begin
                if (sp == '0) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end else begin
                    pop_en = 1'b1;
                    if (top_close) begin
                        ld_tok      = 1'b1;
                        tok_type_nx = TOK_CLOSE;
                        state_nx    = EMIT;
                    end else if (top_i == top_j) begin
                        ld_tok      = 1'b1;
                        tok_type_nx = TOK_MAT;
                        tok_idx_nx  = top_i;
                        state_nx    = EMIT;
                    end else begin
                        state_nx = RD_K;
                    end
                end
            end
            RD_K: begin
                sol_rd   = 1'b1;
                sol_sel  = 1'b1;
                sol_i    = cur_i;
                sol_j    = cur_j;
                state_nx = WAIT_K;
            end
            WAIT_K: begin
                if (cnt_hit) begin
                    // a split must land inside [i, j-1] and three entries must fit
                    if (k < cur_i || k >= cur_j || int'(sp) + 3 > DEPTH) begin
                        state_nx = ERR;
                    end else begin
                        push_split  = 1'b1;
                        ld_tok      = 1'b1;
                        tok_type_nx = TOK_OPEN;
                        state_nx    = EMIT;
                    end
                end
            end
            EMIT: begin
                if (tok_ready) state_nx = POP;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath registers: stack pointer, current node, latency counter, outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp         <= '0;
            n_reg      <= 8'd0;
            cur_i      <= 8'd0;
            cur_j      <= 8'd0;
            cnt        <= '0;
            total_cost <= 32'd0;
            cost_valid <= 1'b0;
            tok_type   <= 2'd0;
            tok_idx    <= 8'd0;
        end else begin
            cnt <= ((state == WAIT_COST || state == WAIT_K) && !cnt_hit) ? cnt + CW'(1) : '0;
            if (ld_tok) begin
                tok_type <= tok_type_nx;
                tok_idx  <= tok_idx_nx;
            end
            if (start_acc) begin
                n_reg      <= n;
                sp         <= '0;
                total_cost <= 32'd0;
                cost_valid <= 1'b0;
            end
            if (ld_root) begin
                sp         <= SPW'(1);
                cost_valid <= 1'b1;
                total_cost <= load_cost ? sol_data : 32'd0;
            end
            if (pop_en) begin
                sp    <= sp - SPW'(1);
                cur_i <= top_i;
                cur_j <= top_j;
            end
            if (push_split) sp <= sp + SPW'(3);
        end
    end

    // Stack storage; pushes CLOSE, right child, left child so left pops first
    always_ff @(posedge clk) begin
        if (ld_root) begin
            stk_close[0] <= 1'b0;
            stk_i[0]     <= 8'd1;
            stk_j[0]     <= root_j;
        end
        if (push_split) begin
            stk_close[p0] <= 1'b1;
            stk_i[p0]     <= 8'd0;
            stk_j[p0]     <= 8'd0;
            stk_close[p1] <= 1'b0;
            stk_i[p1]     <= k + 8'd1;
            stk_j[p1]     <= cur_j;
            stk_close[p2] <= 1'b0;
            stk_i[p2]     <= cur_i;
            stk_j[p2]     <= k;
        end
    end

endmodule
`default_nettype wire
